// File: rtl/mem_pkg.sv
// Shared definitions for the handshaked data memory: access sizes, FSM states
// and the alignment rule applied to every request.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Size 11 is never legal; halves need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        unique case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for
// writes, lane extraction with sign/zero extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        unused_shifted_hi;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic zero_ext);
        logic signed [7:0]  s;
        logic signed [31:0] sx;
        s  = b;
        sx = s;
        return zero_ext ? {24'd0, b} : sx;
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic zero_ext);
        logic signed [15:0] s;
        logic signed [31:0] sx;
        s  = h;
        sx = s;
        return zero_ext ? {16'd0, h} : sx;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        unique case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                be    = 4'b1111;
                wlane = wdata;
            end
            default: begin
                be    = 4'b0000;
                wlane = wdata;
            end
        endcase
    end

    assign shifted           = rword >> {lane, 3'b000};
    assign unused_shifted_hi = ^shifted[31:16];

    always_comb begin
        rdata = 32'd0;
        unique case (size)
            SIZE_BYTE: rdata = ext8(shifted[7:0], uns);
            SIZE_HALF: rdata = ext16(shifted[15:0], uns);
            SIZE_WORD: rdata = rword;
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request port, programmable wait states and
// sub-word loads/stores; one outstanding request, single-cycle response pulse.
module data_memory_hs
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS) + 2;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t        state, state_nxt;
    logic [3:0]    wcnt, wcnt_nxt;
    logic          accept;
    logic          commit;

    logic          write_p0;
    logic [1:0]    size_p0;
    logic          uns_p0;
    logic [AW-1:0] addr_p0;
    logic [31:0]   wdata_p0;

    logic          err_p0;
    logic [AW-3:0] idx_p0;
    logic [3:0]    be_p0;
    logic [31:0]   wlane_p0;
    logic [31:0]   rword_p0;
    logic [31:0]   load_p0;

    logic          unused_addr_hi;

    // Not reset: contents start at zero and are only changed by committed stores.
    logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

    assign accept         = req_valid && req_ready;
    assign commit         = (state == ST_COMMIT);
    assign unused_addr_hi = ^req_addr[31:AW];

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        req_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_COMMIT;
                    end else begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    state_nxt = ST_COMMIT;
                    wcnt_nxt  = 4'd0;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // p0: request captured on accept, held through WAIT and COMMIT
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= req_write;
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            addr_p0  <= req_addr[AW-1:0];
            wdata_p0 <= req_wdata;
        end
    end

    assign err_p0   = misaligned(size_p0, addr_p0[1:0]);
    assign idx_p0   = addr_p0[AW-1:2];
    assign rword_p0 = mem[idx_p0];

    mem_lane_align u_align (
        .size  (size_p0),
        .uns   (uns_p0),
        .lane  (addr_p0[1:0]),
        .wdata (wdata_p0),
        .rword (rword_p0),
        .be    (be_p0),
        .wlane (wlane_p0),
        .rdata (load_p0)
    );

    always_ff @(posedge clk) begin
        if (commit && write_p0 && !err_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wlane_p0[8*i +: 8];
            end
        end
    end

    // p1: response registered on the edge that leaves COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= commit;
            resp_err   <= commit && err_p0;
            resp_rdata <= (commit && !err_p0 && !write_p0) ? load_p0 : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: a zero-wait and a three-wait instance checked
// against a byte-addressed reference memory with directed and random traffic.
module tb_data_memory_hs;

    localparam int MEMB = 4096 * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          sel = 0;

    logic        rdy0, rv0, re0, rdy1, rv1, re1;
    logic [31:0] rd0, rd1;
    logic        cur_ready, cur_rv, cur_re;
    logic [31:0] cur_rd;

    int vectors = 0;
    int miscompares = 0;

    bit [7:0] mb [2][MEMB];

    always #5 clk = ~clk;

    data_memory_hs #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rdy0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
    );

    data_memory_hs #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rdy1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
    );

    assign cur_ready = (sel == 0) ? rdy0 : rdy1;
    assign cur_rv    = (sel == 0) ? rv0  : rv1;
    assign cur_rd    = (sel == 0) ? rd0  : rd1;
    assign cur_re    = (sel == 0) ? re0  : re1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte store, aliasing modulo the memory size.
    function automatic void model(input int d_i, input bit w, input bit [1:0] sz, input bit u,
                                  input bit [31:0] a, input bit [31:0] d,
                                  output bit [31:0] rd, output bit er);
        int     n;
        int     base;
        longint v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er   = (sz == 2'd3) || (a % n != 0);
        base = int'(a % MEMB);
        rd   = '0;
        if (er) return;
        if (w) begin
            for (int i = 0; i < n; i++) mb[d_i][base + i] = d[8*i +: 8];
            return;
        end
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mb[d_i][base + i]) << (8 * i));
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
    endfunction

    // Called at a negedge with the selected instance idle; returns at the negedge after the pulse.
    task automatic xact(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                        input bit [31:0] d, output bit [31:0] got);
        bit [31:0] exp_rd;
        bit        exp_er;
        int        n;
        int        lat;
        model(sel, w, sz, u, a, d, exp_rd, exp_er);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!cur_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!cur_rv && lat < 40) begin @(negedge clk); lat++; end
        got = cur_rd;
        chk("latency", lat, (sel == 0) ? 2 : 5);
        chk("rdata", cur_rd, exp_rd);
        chk("err", {31'd0, cur_re}, {31'd0, exp_er});
        @(negedge clk);
        chk("pulse", {31'd0, cur_rv}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] got, r, a, d, exp_rd;
        bit        exp_er, saw;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rv0", {31'd0, rv0}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_re1", {31'd0, re1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("rst_rdy1", {31'd0, rdy1}, 32'd1);

        // Reset mid-WAIT aborts a store on the three-wait instance
        sel = 1;
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hCAFEBABE;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rv", {31'd0, rv1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy", {31'd0, rdy1}, 32'd1);
        saw = 1'b0;
        repeat (6) begin @(negedge clk); if (rv1) saw = 1'b1; end
        chk("abort_noresp", {31'd0, saw}, 32'd0);
        xact(0, 2'b10, 0, 32'h40, 0, got);
        chk("abort_word", got, 32'h0);

        // Word store/load with zero wait states
        sel = 0;
        xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, got);
        xact(0, 2'b10, 0, 32'h10, 0, got);
        chk("lw_10", got, 32'hDEADBEEF);

        // Byte stores and signed/unsigned byte loads
        xact(1, 2'b00, 0, 32'h21, 32'h0000007F, got);
        xact(1, 2'b00, 0, 32'h22, 32'hFFFFFF80, got);
        xact(0, 2'b10, 0, 32'h20, 0, got);
        chk("lw_20", got, 32'h00807F00);
        xact(0, 2'b00, 0, 32'h22, 0, got);
        chk("lb_22", got, 32'hFFFFFF80);
        xact(0, 2'b00, 1, 32'h22, 0, got);
        chk("lbu_22", got, 32'h00000080);

        // Halfword store into the upper lanes
        xact(1, 2'b01, 0, 32'h32, 32'h12348001, got);
        xact(0, 2'b01, 0, 32'h32, 0, got);
        chk("lh_32", got, 32'hFFFF8001);
        xact(0, 2'b01, 1, 32'h32, 0, got);
        chk("lhu_32", got, 32'h00008001);
        xact(0, 2'b10, 0, 32'h30, 0, got);
        chk("lw_30", got, 32'h80010000);

        // Misaligned and illegal requests leave memory untouched
        xact(0, 2'b10, 0, 32'h13, 0, got);
        xact(1, 2'b01, 0, 32'h11, 32'h5555AAAA, got);
        xact(1, 2'b11, 0, 32'h10, 32'h01020304, got);
        chk("err_rdata", got, 32'h0);
        xact(0, 2'b10, 0, 32'h10, 0, got);
        chk("lw_10_kept", got, 32'hDEADBEEF);

        // Back-to-back requests on the three-wait instance, with address aliasing
        sel = 1;
        model(1, 1, 2'b10, 0, 32'h4010, 32'h12345678, exp_rd, exp_er);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h4010; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(negedge clk);
        model(1, 0, 2'b10, 0, 32'h0010, 0, exp_rd, exp_er);
        req_write = 1'b0; req_addr = 32'h0010; req_wdata = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            chk("b2b_busy", {31'd0, rdy1}, 32'd0);
            chk("b2b_norv", {31'd0, rv1}, 32'd0);
            @(negedge clk);
        end
        chk("b2b_rv_a", {31'd0, rv1}, 32'd1);
        chk("b2b_rdy_a", {31'd0, rdy1}, 32'd1);
        chk("b2b_rd_a", rd1, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_acc_b", {31'd0, rdy1}, 32'd0);
        chk("b2b_rv_off", {31'd0, rv1}, 32'd0);
        repeat (4) @(negedge clk);
        chk("b2b_rv_b", {31'd0, rv1}, 32'd1);
        chk("b2b_rd_b", rd1, exp_rd);
        chk("b2b_alias", rd1, 32'h12345678);
        @(negedge clk);

        // Random traffic on both instances against the reference memory
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 1));
            r = $urandom;
            a = {r[31:14], 8'd0, r[5:0]};
            d = $urandom;
            xact(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, d, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
